// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: drives the PC into the instruction RAM, buffers {pc,instr} in a FIFO,
// handles redirects and HALT. Optional stall counter guarded by IFETCH_PERF_CNT_EN.
module instr_fetch_ctrl #(
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [3:0]  RESET_PC    = 4'h0,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  imem_pc,
  input  logic [15:0] imem_instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [3:0]  redirect_pc,
  input  logic        resume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [3:0]  out_pc,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] instr;
  } fentry_t;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  fentry_t       fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    fetch_pc_q;
  state_t        state_q;

  logic fetch_fire, pop, push_halt;

  assign imem_pc    = fetch_pc_q;
  assign out_valid  = (count_q != '0);
  assign out_instr  = fifo_q[rd_ptr_q].instr;
  assign out_pc     = fifo_q[rd_ptr_q].pc;
  assign halted     = (state_q == S_HALTED);

  // No bypass: a full FIFO blocks fetch even when the head is popped this cycle.
  assign fetch_fire = (state_q == S_RUN) && fetch_en && (count_q < DEPTH_C) && !redirect_valid;
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign push_halt  = fetch_fire && (imem_instr[15:12] == HALT_OPCODE);

  always_comb begin
    count_d = count_q;
    case ({fetch_fire, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      state_q    <= S_RUN;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      state_q    <= S_RUN;
    end else begin
      count_q <= count_d;
      if (fetch_fire) begin
        fetch_pc_q <= fetch_pc_q + 4'd1;
        wr_ptr_q   <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        S_RUN:    if (push_halt) state_q <= S_HALTED;
        S_HALTED: if (resume)    state_q <= S_RUN;
        default:                 state_q <= S_RUN;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (fetch_fire) fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_instr};
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!reset)
      stall_q <= '0;
    else if (out_valid && !out_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural 16x16 instruction RAM.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  imem_pc;
  logic [15:0] imem_instr;
  logic        fetch_en, redirect_valid, resume, out_valid, out_ready, halted;
  logic [3:0]  redirect_pc, out_pc;
  logic [15:0] out_instr, stall_cycles;

  logic [15:0] mem [16];
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc];

  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] pc, input logic [15:0] ins);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"},    32'(out_pc),    32'(pc));
    chk({tag, "_instr"}, 32'(out_instr), 32'(ins));
  endtask

  logic [15:0] exp_stall;

  initial begin
    mem[0]  = 16'h1234; mem[1]  = 16'h2452; mem[2]  = 16'h3678; mem[3]  = 16'h4891;
    mem[4]  = 16'h5A5A; mem[5]  = 16'h6B6B; mem[6]  = 16'h7F01; mem[7]  = 16'h8C8C;
    mem[8]  = 16'h8001; mem[9]  = 16'h9ABC; mem[10] = 16'hA55A; mem[11] = 16'hB00B;
    mem[12] = 16'hC00C; mem[13] = 16'hD00D; mem[14] = 16'hE00E; mem[15] = 16'h0F0F;
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 4'h0; resume = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid",  32'(out_valid),    32'd0);
    chk("rst_halted", 32'(halted),       32'd0);
    chk("rst_pc",     32'(imem_pc),      32'd0);
    chk("rst_stall",  32'(stall_cycles), 32'd0);

    // Streaming, one instruction per cycle
    reset = 1'b1;
    tick(); chk_out("s0", 4'd0, 16'h1234); chk("s0_imem", 32'(imem_pc), 32'd1);
    tick(); chk_out("s1", 4'd1, 16'h2452);
    tick(); chk_out("s2", 4'd2, 16'h3678);
    tick(); chk_out("s3", 4'd3, 16'h4891);

    // fetch_en=0 holds PC while pops continue
    fetch_en = 1'b0;
    tick();
    chk("fen0_valid", 32'(out_valid), 32'd0);
    chk("fen0_imem",  32'(imem_pc),   32'd4);
    fetch_en = 1'b1;

    // Backpressure after reset
    reset = 1'b0; tick();
    reset = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk_out("bp_head", 4'd0, 16'h1234);
    chk("bp_imem", 32'(imem_pc), 32'd2);
`ifdef IFETCH_PERF_CNT_EN
    exp_stall = 16'd4;
`else
    exp_stall = 16'd0;
`endif
    chk("bp_stall", 32'(stall_cycles), 32'(exp_stall));
    out_ready = 1'b1;
    tick(); chk_out("bp_r1", 4'd1, 16'h2452); chk("bp_r1_imem", 32'(imem_pc), 32'd2);
    tick(); chk_out("bp_r2", 4'd2, 16'h3678);
    chk("bp_stall2", 32'(stall_cycles), 32'(exp_stall));

    // Fill with pc 3,4 then redirect to 6
    tick(); chk_out("rd_h3", 4'd3, 16'h4891);
    out_ready = 1'b0;
    tick(); chk_out("rd_full", 4'd3, 16'h4891); chk("rd_full_imem", 32'(imem_pc), 32'd5);
    redirect_valid = 1'b1; redirect_pc = 4'd6; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(out_valid), 32'd0);
    chk("rd_flush_imem",  32'(imem_pc),   32'd6);
    tick(); chk_out("rd_new", 4'd6, 16'h7F01);

    // HALT at address 9, then resume
    mem[9] = 16'hF000;
    redirect_valid = 1'b1; redirect_pc = 4'd8;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("h8", 4'd8, 16'h8001); chk("h8_halted", 32'(halted), 32'd0);
    tick(); chk_out("h9", 4'd9, 16'hF000);
    chk("h9_halted", 32'(halted), 32'd1);
    chk("h9_imem",   32'(imem_pc), 32'd10);
    tick();
    chk("hd_valid",  32'(out_valid), 32'd0);
    chk("hd_halted", 32'(halted),    32'd1);
    tick();
    chk("hd2_valid", 32'(out_valid), 32'd0);
    chk("hd2_imem",  32'(imem_pc),   32'd10);
    resume = 1'b1;
    tick(); resume = 1'b0;
    chk("res_halted", 32'(halted),    32'd0);
    chk("res_valid",  32'(out_valid), 32'd0);
    tick(); chk_out("res_a", 4'd10, 16'hA55A);

    // PC wrap 14,15,0,1
    redirect_valid = 1'b1; redirect_pc = 4'd14;
    tick(); redirect_valid = 1'b0;
    tick(); chk_out("w14", 4'd14, 16'hE00E);
    tick(); chk_out("w15", 4'd15, 16'h0F0F);
    tick(); chk_out("w0",  4'd0,  16'h1234);
    tick(); chk_out("w1",  4'd1,  16'h2452);

    // Reset overrides a redirect with two buffered entries
    out_ready = 1'b0;
    tick(); chk("mr_full_imem", 32'(imem_pc), 32'd3);
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'd5;
    tick();
    chk("mr_valid",  32'(out_valid),    32'd0);
    chk("mr_halted", 32'(halted),       32'd0);
    chk("mr_imem",   32'(imem_pc),      32'd0);
    chk("mr_stall",  32'(stall_cycles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
